dcache_resp: RTL
================

# dcache_resp

Memory-side responder for the pipeline's data-memory request/complete handshake. Accepts `readM`/`writeM` requests from the datapath, serves them from a small direct-mapped, write-through, no-write-allocate cache, and pulses `complete` when the request is finished. Sits between the CPU data port and the slow backing memory port. It is the counterpart of the hazard unit, which stalls the pipeline until `complete`.

## Interface
- `INDEX_BITS`, default 2: log2 of the line count (default 4 lines).
- `WORD_W`, default 16: data and address width.
- Line size is fixed at 4 words. The offset is `address[1:0]`, the index is `address[INDEX_BITS+1:2]`, and the tag is the remaining upper bits.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `readM` in 1: CPU read request, level, held until `complete`.
- `writeM` in 1: CPU write request, level, held until `complete`.
- `address` in WORD_W: CPU word address, stable while a request is held.
- `wdata` in WORD_W: CPU write data.
- `rdata` out WORD_W: read data, valid in the `complete` cycle.
- `complete` out 1: one-cycle done pulse.
- `m_readM` out 1: backing-memory line read request.
- `m_writeM` out 1: backing-memory word write request.
- `m_address` out WORD_W: memory address. For reads it is line-aligned (low 2 bits = 0); for writes it is the word address.
- `m_wdata` out WORD_W: memory write data.
- `m_rdata` in 4*WORD_W: fill line; word 0 is in the LSBs.
- `m_ready` in 1: memory done, one-cycle pulse, any latency of 1 cycle or more.

## Operation
- **States:** IDLE, LOOKUP, FILL, WRITE, DONE.
- **IDLE:**
  - Samples requests.
  - `writeM` high goes to LOOKUP as a write. `writeM` has priority if both requests are high.
  - `readM` high goes to LOOKUP as a read.
  - The request type and address are latched on entry.
- **LOOKUP:** a hit means the line's valid bit is set and the stored tag equals the latched tag.
  - Read hit: go to DONE with the cached word.
  - Read miss: go to FILL.
  - Write, hit or miss: if hit, update the cached word now; then go to WRITE.
  - A write miss does not allocate.
- **FILL:**
  - `m_readM` = 1 and `m_address` = `{tag, index, 2'b00}`.
  - On `m_ready`: store `m_rdata` into the line, set tag and valid, select the requested word, then go to DONE.
- **WRITE:**
  - `m_writeM` = 1, `m_address` = latched address, `m_wdata` = latched `wdata`.
  - On `m_ready`, go to DONE.
- **DONE:**
  - `complete` = 1 for exactly one cycle.
  - `rdata` = result word. `rdata` holds its value until the next read completes.
  - Next state is IDLE.
- A request still held in the IDLE cycle after DONE is sampled again as a new request. The requester must drop or change the request by then.
- `m_readM` and `m_writeM` are never high together. Each stays asserted continuously until its `m_ready`.
- `m_ready` outside FILL/WRITE is ignored.

## Timing
- All outputs are registered from state and datapath registers.
- **Reset values:** `complete` 0, `rdata` 0, `m_readM` 0, `m_writeM` 0, `m_address` 0, `m_wdata` 0, all valid bits 0, state IDLE.
- **Latency**, with request sampled at edge 0:
  - Read hit: `complete` in cycle 2.
  - Read miss, `m_ready` seen at edge k: `complete` in cycle k+1.
  - Write: `complete` in the cycle after `m_ready`.
- A read of the just-filled line immediately after the miss completes is a hit.
- A write hit followed by a read of the same word returns the new data.
- **Reset mid-operation:**
  - Reset asserted in FILL or WRITE aborts the transaction and drops the memory request in the same instant.
  - No `complete` pulse is issued.
  - The cache is fully invalidated.
- Index wrap: addresses differing only in the tag evict each other. The last fill wins.

## Configuration
- Macro `DCACHE_STATS_EN`.
- **Defined:** adds outputs `hit_count` and `miss_count` (16 bits each).
  - Each increments once per LOOKUP, for read and write lookups alike.
  - Each saturates at 16'hFFFF.
  - Both reset to 0.
- **Undefined:** neither port nor counter exists, and request behaviour is identical.

## Test plan
- **Cold read miss:**
  - Stimulus: reset, then read 16'h0005, memory returns line {16'hD3, 16'hD2, 16'hD1, 16'hD0} after 4 cycles.
  - Required: `m_address` = 16'h0004, then `rdata` = 16'hD1 with one `complete`, then a re-read hits with `complete` 2 cycles after the request is sampled.
- **Write-through hit:**
  - Stimulus: after the above, write 16'hBEEF to 16'h0006, then read 16'h0006.
  - Required: `m_writeM` is asserted with 16'hBEEF; the read hits and returns 16'hBEEF without `m_readM`.
- **Write miss no-allocate:**
  - Stimulus: write to 16'h0040, then read 16'h0040.
  - Required: the read misses and issues `m_readM` to 16'h0040.
- **Conflict eviction:**
  - Stimulus: read 16'h0004, read 16'h0014 (same index, different tag), read 16'h0004.
  - Required: three fills.
- **Simultaneous `readM` and `writeM`, then reset during FILL:**
  - Stimulus: `readM` and `writeM` high together; separately, assert reset during FILL.
  - Required: the simultaneous request is serviced as a write. The reset gives no `complete`, both memory requests drop to 0, and the next read of that line misses.
- **Stats** (with `DCACHE_STATS_EN` defined):
  - Stimulus: 2 misses, then 3 hits.
  - Required: `miss_count` = 2, `hit_count` = 3.

Source files
------------

// File: rtl/dcache_resp.sv
// ---------------------------------------------------------------------------
// dcache_resp
//   Memory-side responder for the pipeline data port. Serves readM/writeM
//   requests from a direct-mapped, write-through, no-write-allocate cache of
//   2**INDEX_BITS lines x 4 words, and pulses `complete` when done.
//
// Ports
//   clk, reset_n           : clock (rising edge), async active-low reset
//   readM, writeM          : CPU requests, level, held until complete
//   address, wdata         : CPU word address / write data
//   rdata, complete        : read result (held until next read) / done pulse
//   m_readM, m_writeM      : backing-memory line read / word write requests
//   m_address, m_wdata     : backing-memory address / write data
//   m_rdata, m_ready       : fill line (word 0 in LSBs) / memory done pulse
//   hit_count, miss_count  : lookup statistics, only with DCACHE_STATS_EN
//
// Configuration macro: DCACHE_STATS_EN adds saturating hit/miss counters.
// ---------------------------------------------------------------------------
module dcache_resp #(
    parameter int INDEX_BITS = 2,
    parameter int WORD_W     = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                readM,
    input  logic                writeM,
    input  logic [WORD_W-1:0]   address,
    input  logic [WORD_W-1:0]   wdata,
    output logic [WORD_W-1:0]   rdata,
    output logic                complete,
    output logic                m_readM,
    output logic                m_writeM,
    output logic [WORD_W-1:0]   m_address,
    output logic [WORD_W-1:0]   m_wdata,
    input  logic [4*WORD_W-1:0] m_rdata,
    input  logic                m_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count
`endif
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = WORD_W - INDEX_BITS - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_FILL,
        S_WRITE,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    // Latched request
    logic              req_write_q, req_write_d;
    logic [WORD_W-1:0] req_addr_q,  req_addr_d;
    logic [WORD_W-1:0] req_wdata_q, req_wdata_d;

    // Registered outputs
    logic [WORD_W-1:0] rdata_q,     rdata_d;
    logic              complete_q,  complete_d;
    logic              m_read_q,    m_read_d;
    logic              m_write_q,   m_write_d;
    logic [WORD_W-1:0] m_address_q, m_address_d;
    logic [WORD_W-1:0] m_wdata_q,   m_wdata_d;

    // Cache arrays
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [TAG_W-1:0]  tag_d  [LINES];
    logic [WORD_W-1:0] data_q [LINES][4];
    logic [WORD_W-1:0] data_d [LINES][4];

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [1:0]            req_off;
    logic                  hit;
    logic [WORD_W-1:0]     fill_words [4];

    assign req_idx = req_addr_q[INDEX_BITS+1:2];
    assign req_tag = req_addr_q[WORD_W-1:INDEX_BITS+2];
    assign req_off = req_addr_q[1:0];
    assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            fill_words[i] = m_rdata[i*WORD_W +: WORD_W];
        end
    end

    // NOTE: every signal written below gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        rdata_d     = rdata_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;

        case (state_q)
            S_IDLE: begin
                if (writeM || readM) begin
                    state_d     = S_LOOKUP;
                    req_write_d = writeM;   // write wins when both are high
                    req_addr_d  = address;
                    req_wdata_d = wdata;
                end
            end
            S_LOOKUP: begin
                if (req_write_q) begin
                    // Write-through: update on hit only, never allocate.
                    if (hit) begin
                        data_d[req_idx][req_off] = req_wdata_q;
                    end
                    state_d = S_WRITE;
                end else if (hit) begin
                    rdata_d = data_q[req_idx][req_off];
                    state_d = S_DONE;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (m_ready) begin
                    for (int i = 0; i < 4; i++) begin
                        data_d[req_idx][i] = fill_words[i];
                    end
                    tag_d[req_idx]   = req_tag;
                    valid_d[req_idx] = 1'b1;
                    rdata_d          = fill_words[req_off];
                    state_d          = S_DONE;
                end
            end
            S_WRITE: begin
                if (m_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so each is a clean flop.
    always_comb begin
        complete_d  = (state_d == S_DONE);
        m_read_d    = (state_d == S_FILL);
        m_write_d   = (state_d == S_WRITE);
        m_address_d = m_address_q;
        m_wdata_d   = m_wdata_q;
        if (state_d == S_FILL) begin
            m_address_d = {req_addr_q[WORD_W-1:2], 2'b00};
        end else if (state_d == S_WRITE) begin
            m_address_d = req_addr_q;
            m_wdata_d   = req_wdata_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            rdata_q     <= '0;
            complete_q  <= 1'b0;
            m_read_q    <= 1'b0;
            m_write_q   <= 1'b0;
            m_address_q <= '0;
            m_wdata_q   <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            rdata_q     <= rdata_d;
            complete_q  <= complete_d;
            m_read_q    <= m_read_d;
            m_write_q   <= m_write_d;
            m_address_q <= m_address_d;
            m_wdata_q   <= m_wdata_d;
            valid_q     <= valid_d;
        end
    end

    // NOTE: tag and data arrays are not reset; the valid bits alone gate
    // their use, which keeps the arrays mappable onto plain RAM.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rdata     = rdata_q;
    assign complete  = complete_q;
    assign m_readM   = m_read_q;
    assign m_writeM  = m_write_q;
    assign m_address = m_address_q;
    assign m_wdata   = m_wdata_q;

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_count_q,  hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == S_LOOKUP) begin
            if (hit) begin
                if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
            end else begin
                if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
